// File: rtl/unified_mem.sv
// unified_mem: shared instruction/data word memory with power-on clear.
// Ports: clk, rst_n (sync, active-low); busy while clearing;
//   fetch port i_req/i_addr -> i_valid/i_data (1-cycle latency, address wraps);
//   data port d_req/d_we/d_be/d_addr/d_wdata -> d_ack/d_rdata/d_err (1-cycle latency).
module unified_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                busy,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BW = DATA_W / 8;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic i_valid_q, d_ack_q, d_err_q;
  logic [DATA_W-1:0] i_data_q, d_rdata_q, wmerge, mem_wd;
  logic [AW-1:0] ia, da, mem_wa;
  logic run, d_oor, d_wr, mem_we, unused_i;
  assign ia = i_addr[AW-1:0];
  assign da = d_addr[AW-1:0];
  assign unused_i = ^i_addr;
  assign run = state_q == RUN;
  assign d_oor = {1'b0, d_addr} >= (ADDR_W+1)'(DEPTH);
  assign d_wr = run && d_req && d_we && !d_oor;
  assign busy = !run;
  assign i_valid = i_valid_q;
  assign i_data = i_data_q;
  assign d_ack = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_err = d_err_q;
  // Byte-lane merge of write data into the addressed word; also feeds the fetch path on a collision.
  always_comb begin
    wmerge = mem[da];
    for (int k = 0; k < BW; k++) wmerge[8*k +: 8] = d_be[k] ? d_wdata[8*k +: 8] : mem[da][8*k +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == AW'(DEPTH - 1) ? RUN : CLEAR;
    end
    mem_we = rst_n && (!run || d_wr);
    mem_wa = run ? da : cnt_q;
    mem_wd = run ? wmerge : '0;
  end
  always_ff @(posedge clk) if (mem_we) mem[mem_wa] <= mem_wd;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      i_valid_q <= 1'b0;
      i_data_q <= '0;
      d_ack_q <= 1'b0;
      d_rdata_q <= '0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      i_valid_q <= run && i_req;
      if (run && i_req) i_data_q <= d_wr && da == ia ? wmerge : mem[ia];
      d_ack_q <= run && d_req;
      d_err_q <= run && d_req && d_oor;
      if (run && d_req && (!d_we || d_oor)) d_rdata_q <= d_oor ? '0 : mem[da];
    end
  end
endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: randomized self-checking bench for unified_mem against a word-array model.
module tb_unified_mem;
  localparam int DEPTH = 128;
  logic clk = 0, rst_n = 0, busy, i_req = 0, i_valid, d_req = 0, d_we = 0, d_ack, d_err;
  logic [15:0] i_addr = 0, i_data, d_addr = 0, d_wdata = 0, d_rdata;
  logic [1:0] d_be = 0;
  logic [15:0] mdl [DEPTH];
  logic [15:0] e_id, e_rd;
  int errors = 0, checks = 0;
  unified_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                       input logic [1:0] dbe, input logic [15:0] dad, input logic [15:0] dwd);
    logic [15:0] w;
    logic oor;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_be = dbe; d_addr = dad; d_wdata = dwd;
    oor = int'(dad) >= DEPTH;
    if (dr) e_rd = oor ? 16'h0 : (dwe ? e_rd : mdl[int'(dad)]);
    if (dr && dwe && !oor) begin
      w = mdl[int'(dad)];
      for (int k = 0; k < 2; k++) if (dbe[k]) w[8*k +: 8] = dwd[8*k +: 8];
      mdl[int'(dad)] = w;
    end
    if (ir) e_id = mdl[int'(ia) % DEPTH];
    cycle();
    chk("i_valid", i_valid, ir);
    chk("i_data", i_data, e_id);
    chk("d_ack", d_ack, dr);
    chk("d_err", d_err, dr && oor);
    chk("d_rdata", d_rdata, e_rd);
  endtask
  task automatic do_reset();
    rst_n = 0; i_req = 0; d_req = 1; d_we = 0; d_addr = 9;
    cycle();
    chk("rst_busy", busy, 1);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_i_data", i_data, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_d_err", d_err, 0);
    for (int a = 0; a < DEPTH; a++) mdl[a] = 0;
    e_id = 0; e_rd = 0;
    rst_n = 1;
  endtask
  task automatic measure_clear();
    int n = 0;
    logic seen = 0;
    while (busy && n < 300) begin
      n++;
      if (d_ack || i_valid) seen = 1;
      cycle();
    end
    chk("clear_len", n, DEPTH);
    chk("clear_noack", seen | d_ack, 0);
    d_req = 0;
  endtask
  initial begin
    logic ir, dr, dwe;
    logic [15:0] ia, dad;
    do_reset();
    measure_clear();
    drive(0, 0, 1, 0, 0, 0, 0);    chk("clr_rd0", d_rdata, 0);
    drive(0, 0, 1, 0, 0, 64, 0);   chk("clr_rd64", d_rdata, 0);
    drive(0, 0, 1, 0, 0, 127, 0);  chk("clr_rd127", d_rdata, 0);
    drive(0, 0, 1, 1, 2'b11, 3, 16'hAAAA);
    drive(0, 0, 1, 1, 2'b01, 3, 16'h1255);
    drive(0, 0, 1, 0, 0, 3, 0);
    chk("be_merge", d_rdata, 16'hAA55);
    chk("be_ack", d_ack, 1);
    chk("be_err", d_err, 0);
    drive(1, 5, 1, 1, 2'b11, 5, 16'h1234);
    chk("coll_valid", i_valid, 1);
    chk("coll_data", i_data, 16'h1234);
    drive(0, 0, 1, 1, 2'b11, 72, 16'h7272);
    drive(0, 0, 1, 0, 0, 200, 0);
    chk("oor_err", d_err, 1);
    chk("oor_rdata", d_rdata, 0);
    drive(0, 0, 1, 1, 2'b11, 200, 16'hBEEF);
    drive(0, 0, 1, 0, 0, 72, 0);
    chk("oor_nowrite", d_rdata, 16'h7272);
    drive(1, 16'h0085, 0, 0, 0, 0, 0);
    chk("fetch_wrap", i_data, 16'h1234);
    drive(0, 0, 1, 1, 2'b00, 72, 16'h0000);
    drive(0, 0, 1, 0, 0, 72, 0);
    chk("be0_nochange", d_rdata, 16'h7272);
    for (int c = 0; c < 1500; c++) begin
      ir = $urandom_range(0, 3) != 0;
      ia = 16'($urandom);
      dr = $urandom_range(0, 3) != 0;
      dwe = 1'($urandom);
      dad = $urandom_range(0, 7) == 0 ? 16'($urandom_range(128, 65535)) :
            $urandom_range(0, 3) == 0 ? 16'(int'(ia) % DEPTH) : 16'($urandom_range(0, 31));
      drive(ir, ia, dr, dwe, 2'($urandom), dad, 16'($urandom));
    end
    do_reset();
    repeat (40) cycle();
    chk("mid_busy", busy, 1);
    do_reset();
    measure_clear();
    drive(0, 0, 1, 1, 2'b11, 9, 16'h5A5A);
    d_req = 1; d_we = 0; d_addr = 9;
    cycle();
    do_reset();
    chk("inflight_noack", d_ack, 0);
    measure_clear();
    drive(0, 0, 1, 0, 0, 9, 0);
    chk("recleared", d_rdata, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unified_mem.md
UNIFIED_MEM -- requirements
Module: unified_mem

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16: address width of both ports.
REQ-003 Parameter DEPTH, default 128: number of words; SHALL be a power of 2 and <= 2**ADDR_W.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port busy  output  1  high while power-on clear is in progress.
REQ-007 Port i_req  input  1  instruction fetch request.
REQ-008 Port i_addr  input  ADDR_W  fetch word address.
REQ-009 Port i_valid  output  1  i_data holds a fetch result this cycle.
REQ-010 Port i_data  output  DATA_W  fetched word.
REQ-011 Port d_req  input  1  data access request.
REQ-012 Port d_we  input  1  1 = write, 0 = read; qualified by d_req.
REQ-013 Port d_be  input  DATA_W/8  byte-lane write enables; bit k covers bits 8k+7..8k.
REQ-014 Port d_addr  input  ADDR_W  data word address.
REQ-015 Port d_wdata  input  DATA_W  write data.
REQ-016 Port d_ack  output  1  one-cycle pulse completing an accepted data access.
REQ-017 Port d_rdata  output  DATA_W  read data, valid when d_ack=1 and the access was a read.
REQ-018 Port d_err  output  1  with d_ack: access was out of range.

Function
REQ-019 Two states, CLEAR and RUN; reset enters CLEAR with the clear counter at 0.
REQ-020 CLEAR: each cycle write 0 to mem[counter], increment counter; after writing DEPTH-1, go to RUN next cycle; busy=1 throughout CLEAR, 0 in RUN.
REQ-021 In CLEAR, i_req and d_req are ignored: no ack, no valid, no array write.
REQ-022 RUN fetch: i_req=1 at edge N -> i_valid=1 and i_data=mem[i_addr mod DEPTH] after edge N; latency 1 cycle; back-to-back fetches every cycle.
REQ-023 i_req=0 at an edge -> i_valid=0 after it; i_data holds its previous value.
REQ-024 RUN data: d_req=1 at edge N -> d_ack=1 for exactly the cycle after edge N; a new request is accepted every cycle.
REQ-025 Write: bytes with d_be[k]=1 take d_wdata at edge N; other bytes unchanged; d_rdata holds previous value.
REQ-026 Read: d_rdata=mem[d_addr] as it was before edge N.
REQ-027 Out of range (d_addr >= DEPTH): no array change, d_rdata=0, d_ack=1 and d_err=1; otherwise d_err=0.
REQ-028 Fetch addresses are not range-checked; the upper address bits are ignored (wrap modulo DEPTH).
REQ-029 Collision: fetch and in-range write to the same word at the same edge -> i_data returns the post-write word (write-first, merged by d_be).
REQ-030 Fetch and data read at the same edge, any addresses: both served, no stall.
REQ-031 d_be=0 write: no array change, still acked with d_err=0.

Reset
REQ-032 rst_n=0 at an edge -> busy=1, i_valid=0, i_data=0, d_ack=0, d_rdata=0, d_err=0 after that edge.
REQ-033 Reset during CLEAR or RUN aborts any access in flight: no ack is issued for it, and the clear restarts at address 0.
REQ-034 Array contents are defined only via the clear sequence; no dependence on simulation initial values.

Verification
REQ-035 Release reset with DEPTH=128 -> busy high for exactly 128 cycles; a d_req issued during that time gets no d_ack; afterwards reads of 0, 64 and 127 return 0.
REQ-036 Write 0xAAAA to address 3 with d_be=11, then write 0x1255 with d_be=01 -> read of address 3 returns 0xAA55 with d_ack=1 and d_err=0.
REQ-037 Same edge: fetch address 5 and write 0x1234 to address 5 with d_be=11 -> i_valid=1 and i_data=0x1234 the next cycle.
REQ-038 Read address 200 with DEPTH=128 -> d_ack=1, d_err=1, d_rdata=0; a write to address 200 leaves address 72 unchanged.
REQ-039 Fetch i_addr=0x0085 with DEPTH=128 -> returns mem[5].
REQ-040 Pulse rst_n low 40 cycles into CLEAR, and again in RUN while a read is in flight -> the read gets no d_ack, busy reasserts, and the clear runs a full 128 cycles again.
